// File: rtl/conn_table.sv
// conn_table: hashed connection table; linear-probe lookup that inserts on first empty slot.
// Optional macro CONN_TABLE_CLEAR_EN: slot valid bits held in RAM and swept by a CLEAR state after reset.
module conn_table #(
    parameter int unsigned HASH_LEN = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] tuple_data_i,
    input  logic         tuple_valid_i,
    output logic [15:0]  conn_data_o,
    output logic         conn_valid_o,
    output logic         conn_miss_o,
    output logic [16:0]  count_o,
    output logic         busy_o
);

    localparam int unsigned KEY_W  = 104;
    localparam int unsigned DEPTH  = 1 << HASH_LEN;
    localparam int unsigned NCHUNK = (KEY_W + HASH_LEN - 1) / HASH_LEN;
    localparam int unsigned PAD_W  = NCHUNK * HASH_LEN;
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PROBE    = 3'd1,
        S_RESP     = 3'd2,
        S_WAIT_LOW = 3'd3,
        S_CLEAR    = 3'd4
    } state_t;

`ifdef CONN_TABLE_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    // Fold the key into HASH_LEN-bit chunks starting at bit 0; top chunk is zero-padded.
    function automatic logic [HASH_LEN-1:0] f_hash(input logic [KEY_W-1:0] key);
        logic [PAD_W-1:0]    padded;
        logic [HASH_LEN-1:0] acc;
        padded = PAD_W'(key);
        acc    = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            acc = acc ^ padded[i*HASH_LEN +: HASH_LEN];
        end
        return acc;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;

    logic [KEY_W-1:0]    r_key;
    logic [HASH_LEN-1:0] r_idx;
    logic [HASH_LEN-1:0] r_cnt;
    logic                r_resp_miss;

    logic [KEY_W-1:0]    r_keys [DEPTH];
`ifdef CONN_TABLE_CLEAR_EN
    logic                r_valid [DEPTH];
    logic [HASH_LEN-1:0] r_clr_idx;
`else
    logic [DEPTH-1:0]    r_valid;
`endif

    logic [DATA_W-1:0]   r_conn_data;
    logic                r_conn_valid;
    logic                r_conn_miss;
    logic [CNT_W-1:0]    r_count;
    logic                r_busy;

    logic                w_slot_valid;
    logic [KEY_W-1:0]    w_slot_key;
    logic                w_hit;
    logic                w_empty;
    logic                w_last;
    logic                w_clr_last;

    logic                w_accept;
    logic                w_advance;
    logic                w_resolve;
    logic                w_insert;
    logic                w_miss;
    logic                w_respond;
    logic                w_clear;

    logic                w_unused_hi;
    assign w_unused_hi = ^tuple_data_i[127:KEY_W];

    // Current probe slot
    assign w_slot_valid = r_valid[r_idx];
    assign w_slot_key   = r_keys[r_idx];
    assign w_hit        = w_slot_valid && (w_slot_key == r_key);
    assign w_empty      = !w_slot_valid;
    assign w_last       = (r_cnt == HASH_LEN'(DEPTH - 1));
`ifdef CONN_TABLE_CLEAR_EN
    assign w_clr_last   = (r_clr_idx == HASH_LEN'(DEPTH - 1));
`else
    assign w_clr_last   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (tuple_valid_i) w_state_nxt = S_PROBE;
            S_PROBE:    if (w_hit || w_empty || w_last) w_state_nxt = S_RESP;
            S_RESP:     w_state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: if (!tuple_valid_i) w_state_nxt = S_IDLE;
            S_CLEAR:    if (w_clr_last) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_accept  = 1'b0;
        w_advance = 1'b0;
        w_resolve = 1'b0;
        w_insert  = 1'b0;
        w_miss    = 1'b0;
        w_respond = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = tuple_valid_i;
            end
            S_PROBE: begin
                w_resolve = w_hit || w_empty || w_last;
                w_advance = !w_resolve;
                w_insert  = w_empty;
                w_miss    = !w_hit && !w_empty && w_last;
            end
            S_RESP: begin
                w_respond = 1'b1;
            end
            S_CLEAR: begin
                w_clear = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Probe datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_key        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_resp_miss  <= 1'b0;
            r_conn_data  <= '0;
            r_conn_valid <= 1'b0;
            r_conn_miss  <= 1'b0;
            r_count      <= '0;
            r_busy       <= RESET_BUSY;
        end else begin
            if (w_accept) begin
                r_key <= tuple_data_i[KEY_W-1:0];
                r_idx <= f_hash(tuple_data_i[KEY_W-1:0]);
                r_cnt <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + HASH_LEN'(1);
                r_cnt <= r_cnt + HASH_LEN'(1);
            end
            if (w_resolve) begin
                r_resp_miss <= w_miss;
            end
            if (w_insert && (r_count != CNT_W'(DEPTH))) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_conn_valid <= w_respond;
            if (w_respond) begin
                r_conn_miss <= r_resp_miss;
                r_conn_data <= r_resp_miss ? 16'hFFFF : DATA_W'(r_idx);
            end
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    // Key storage needs no reset; the valid bits decide what is live
    always_ff @(posedge clk) begin
        if (reset && w_insert) begin
            r_keys[r_idx] <= r_key;
        end
    end

`ifdef CONN_TABLE_CLEAR_EN
    // Valid bits in RAM: one slot cleared per cycle while sweeping
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_valid[r_clr_idx] <= 1'b0;
        end else if (reset && w_insert) begin
            r_valid[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clr_idx <= '0;
        end else if (w_clear) begin
            r_clr_idx <= r_clr_idx + HASH_LEN'(1);
        end
    end
`else
    // Valid bits in flops, all cleared in the reset cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (w_insert) begin
            r_valid[r_idx] <= 1'b1;
        end
    end
`endif

    assign conn_data_o  = r_conn_data;
    assign conn_valid_o = r_conn_valid;
    assign conn_miss_o  = r_conn_miss;
    assign count_o      = r_count;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_conn_table.sv
// tb_conn_table: directed self-checking bench for conn_table (HASH_LEN=6, default build).
module tb_conn_table;

    logic         clk;
    logic         reset;
    logic [127:0] tuple_data_i;
    logic         tuple_valid_i;
    logic [15:0]  conn_data_o;
    logic         conn_valid_o;
    logic         conn_miss_o;
    logic [16:0]  count_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    conn_table #(.HASH_LEN(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .tuple_data_i  (tuple_data_i),
        .tuple_valid_i (tuple_valid_i),
        .conn_data_o   (conn_data_o),
        .conn_valid_o  (conn_valid_o),
        .conn_miss_o   (conn_miss_o),
        .count_o       (count_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Issue one request; latency counts edges after the accept edge. Key is scrambled after acceptance.
    task automatic do_req(input logic [103:0] key, input int hold_extra, input int budget,
                          output int lat, output logic [15:0] data, output logic miss,
                          output int nresp);
        lat   = -1;
        data  = 16'hxxxx;
        miss  = 1'bx;
        nresp = 0;
        @(negedge clk);
        tuple_data_i  = {24'hABCDEF, key};
        tuple_valid_i = 1'b1;
        for (int n = 0; n < budget && lat < 0; n++) begin
            @(negedge clk);
            if (n == 0) tuple_data_i = ~tuple_data_i;
            if (conn_valid_o) begin
                lat   = n;
                data  = conn_data_o;
                miss  = conn_miss_o;
                nresp = nresp + 1;
            end
        end
        for (int n = 0; n < 1 + hold_extra; n++) begin
            @(negedge clk);
            if (conn_valid_o) nresp = nresp + 1;
        end
        tuple_valid_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (conn_valid_o) nresp = nresp + 1;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        tuple_valid_i = 1'b0;
        tuple_data_i  = '0;
        repeat (3) @(negedge clk);
        checks++; if (conn_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", conn_valid_o); end
        checks++; if (conn_miss_o !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", conn_miss_o); end
        checks++; if (conn_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", conn_data_o); end
        checks++; if (count_o !== 17'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_first_insert();
        int lat, nresp; logic [15:0] data; logic miss;
        do_req(104'h1, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL first_lat: got %0d expected 2", lat); end
        checks++; if (data !== 16'd1) begin errors++; $display("FAIL first_data: got %h expected 0001", data); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL first_miss: got %b expected 0", miss); end
        checks++; if (count_o !== 17'd1) begin errors++; $display("FAIL first_count: got %0d expected 1", count_o); end
        checks++; if (nresp !== 1) begin errors++; $display("FAIL first_nresp: got %0d expected 1", nresp); end
        checks++; if (conn_data_o !== 16'd1) begin errors++; $display("FAIL first_hold: got %h expected 0001", conn_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL first_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_repeat_hit();
        int lat, nresp; logic [15:0] data; logic miss;
        do_req(104'h1, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_lat: got %0d expected 2", lat); end
        checks++; if (data !== 16'd1) begin errors++; $display("FAIL hit_data: got %h expected 0001", data); end
        checks++; if (count_o !== 17'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", count_o); end
    endtask

    task automatic test_collision();
        int lat, nresp; logic [15:0] data; logic miss;
        do_req(104'h40, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 3) begin errors++; $display("FAIL coll_lat: got %0d expected 3", lat); end
        checks++; if (data !== 16'd2) begin errors++; $display("FAIL coll_data: got %h expected 0002", data); end
        checks++; if (count_o !== 17'd2) begin errors++; $display("FAIL coll_count: got %0d expected 2", count_o); end
        do_req(104'h0, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_lat: got %0d expected 2", lat); end
        checks++; if (data !== 16'd0) begin errors++; $display("FAIL zero_data: got %h expected 0000", data); end
        checks++; if (count_o !== 17'd3) begin errors++; $display("FAIL zero_count: got %0d expected 3", count_o); end
    endtask

    // Key 0x41 hashes to 0; slots 0,1,2 are taken, so it lands in slot 3 on probe 3
    task automatic test_probe_chain();
        int lat, nresp; logic [15:0] data; logic miss;
        do_req(104'h41, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 5) begin errors++; $display("FAIL chain_lat: got %0d expected 5", lat); end
        checks++; if (data !== 16'd3) begin errors++; $display("FAIL chain_data: got %h expected 0003", data); end
        checks++; if (count_o !== 17'd4) begin errors++; $display("FAIL chain_count: got %0d expected 4", count_o); end
    endtask

    task automatic test_fill_and_miss();
        int lat, nresp; logic [15:0] data; logic miss;
        for (int i = 4; i < 64; i++) begin
            do_req(104'(i), 0, 20, lat, data, miss, nresp);
            checks++; if (data !== 16'(i) || lat !== 2) begin errors++; $display("FAIL fill_%0d: got data %h lat %0d expected data %h lat 2", i, data, lat, 16'(i)); end
        end
        checks++; if (count_o !== 17'd64) begin errors++; $display("FAIL full_count: got %0d expected 64", count_o); end
        do_req(104'h2, 5, 100, lat, data, miss, nresp);
        checks++; if (lat !== 65) begin errors++; $display("FAIL miss_lat: got %0d expected 65", lat); end
        checks++; if (miss !== 1'b1) begin errors++; $display("FAIL miss_flag: got %b expected 1", miss); end
        checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL miss_data: got %h expected ffff", data); end
        checks++; if (nresp !== 1) begin errors++; $display("FAIL miss_nresp: got %0d expected 1", nresp); end
        checks++; if (count_o !== 17'd64) begin errors++; $display("FAIL miss_count: got %0d expected 64", count_o); end
        checks++; if (conn_miss_o !== 1'b1 || conn_data_o !== 16'hFFFF) begin errors++; $display("FAIL miss_hold: got miss %b data %h expected 1 ffff", conn_miss_o, conn_data_o); end
        do_req(104'h41, 0, 100, lat, data, miss, nresp);
        checks++; if (lat !== 5 || data !== 16'd3 || miss !== 1'b0) begin errors++; $display("FAIL full_hit: got lat %0d data %h miss %b expected 5 0003 0", lat, data, miss); end
    endtask

    task automatic test_reset_mid_probe();
        int lat, nresp; logic [15:0] data; logic miss;
        int seen;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_req(104'h1, 0, 20, lat, data, miss, nresp);
        checks++; if (data !== 16'd1 || count_o !== 17'd1) begin errors++; $display("FAIL pre_abort: got data %h count %0d expected 0001 1", data, count_o); end
        @(negedge clk);
        tuple_data_i  = {24'h0, 104'h40};
        tuple_valid_i = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL probe_busy: got %b expected 1", busy_o); end
        reset = 1'b0;
        @(negedge clk);
        reset         = 1'b1;
        tuple_valid_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (conn_valid_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_resp: got %0d strobes expected 0", seen); end
        checks++; if (count_o !== 17'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", count_o); end
        checks++; if (conn_data_o !== 16'd0) begin errors++; $display("FAIL abort_data: got %h expected 0000", conn_data_o); end
        do_req(104'h1, 0, 20, lat, data, miss, nresp);
        checks++; if (lat !== 2 || data !== 16'd1) begin errors++; $display("FAIL post_abort: got lat %0d data %h expected 2 0001", lat, data); end
        checks++; if (count_o !== 17'd1) begin errors++; $display("FAIL post_abort_count: got %0d expected 1", count_o); end
    endtask

    // Request already present on the first edge after reset release must be taken
    task automatic test_accept_after_reset();
        int lat;
        logic [15:0] data;
        @(negedge clk);
        reset         = 1'b0;
        tuple_data_i  = {24'h0, 104'h5};
        tuple_valid_i = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        lat   = -1;
        data  = 16'hxxxx;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 0) tuple_data_i = '1;
            if (conn_valid_o) begin
                lat  = n;
                data = conn_data_o;
            end
        end
        @(negedge clk);
        tuple_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (lat !== 2) begin errors++; $display("FAIL release_lat: got %0d expected 2", lat); end
        checks++; if (data !== 16'd5) begin errors++; $display("FAIL release_data: got %h expected 0005", data); end
        checks++; if (count_o !== 17'd1) begin errors++; $display("FAIL release_count: got %0d expected 1", count_o); end
    endtask

    initial begin
        test_reset();
        test_first_insert();
        test_repeat_hit();
        test_collision();
        test_probe_chain();
        test_fill_and_miss();
        test_reset_mid_probe();
        test_accept_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
